data_memory_port: RTL and testbench



---
 rtl/data_memory_port.sv | 85 ++++++++
 tb/tb_data_memory_port.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/data_memory_port.sv
// data_memory_port: byte-serial 24-bit word responder over an internal byte RAM, big-endian, three beats per word.
// Define BOUNDS_CHECK_EN to reject words that would run past the top of the RAM or use upper address bits.
module data_memory_port #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [23:0] address,
  input  logic [23:0] write_data,
  output logic [23:0] read_data,
  output logic        busy,
  output logic        done,
  output logic        error
);
  typedef enum logic [2:0] {IDLE, BEAT0, BEAT1, BEAT2, DONE} state_t;
  state_t state;
  logic [7:0] ram [2**ADDR_WIDTH];
  logic [ADDR_WIDTH-1:0] addr, baddr;
  logic [23:0] wdata, shadow;
  logic is_read, reject;
  logic [1:0] beat;
  logic [7:0] wbyte, rbyte;
  always_comb begin
    beat = state == BEAT1 ? 2'd1 : state == BEAT2 ? 2'd2 : 2'd0;
    baddr = addr + ADDR_WIDTH'(beat);
    wbyte = beat == 2'd0 ? wdata[23:16] : beat == 2'd1 ? wdata[15:8] : wdata[7:0];
    rbyte = ram[baddr];
  end
`ifdef BOUNDS_CHECK_EN
  // last two byte addresses cannot hold a full word without wrapping
  assign reject = (mem_read & mem_write) | (|address[23:ADDR_WIDTH]) | (&address[ADDR_WIDTH-1:1]);
`else
  logic unused_hi;
  assign unused_hi = ^address[23:ADDR_WIDTH];
  assign reject = mem_read & mem_write;
`endif
  // reset wins over an in-flight beat so a partial store stops at the reset edge
  always_ff @(posedge clock)
    if (!reset && busy && !is_read) ram[baddr] <= wbyte;
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      read_data <= '0;
      shadow <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      error <= 1'b0;
    end else begin
      done <= 1'b0;
      error <= 1'b0;
      case (state)
        IDLE: if (mem_read | mem_write) begin
          is_read <= mem_read;
          addr <= address[ADDR_WIDTH-1:0];
          wdata <= write_data;
          shadow <= '0;
          state <= reject ? DONE : BEAT0;
          busy <= !reject;
          done <= reject;
          error <= reject;
        end
        BEAT0: begin
          state <= BEAT1;
          if (is_read) shadow[23:16] <= rbyte;
        end
        BEAT1: begin
          state <= BEAT2;
          if (is_read) shadow[15:8] <= rbyte;
        end
        BEAT2: begin
          state <= DONE;
          busy <= 1'b0;
          done <= 1'b1;
          if (is_read) begin
            shadow[7:0] <= rbyte;
            read_data <= {shadow[23:8], rbyte};
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_data_memory_port.sv
// tb_data_memory_port: directed transfers with a scoreboard queue checked by a decoupled monitor.
module tb_data_memory_port;
  logic clk = 1'b0, reset, mem_read, mem_write, busy, done, error;
  logic [23:0] address, write_data, read_data;
  int cyc = 0, checks = 0, errors = 0;
  typedef struct {int cyc; logic [23:0] data; logic [23:0] mask; logic err;} exp_t;
  exp_t q[$];
  logic [23:0] rd_model = '0, rd_mask = 24'hFFFFFF;
`ifdef BOUNDS_CHECK_EN
  localparam logic [23:0] WRAP_MASK = 24'h000000;
`else
  localparam logic [23:0] WRAP_MASK = 24'hFFFF00;
`endif

  data_memory_port dut (.clock(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
    .address(address), .write_data(write_data), .read_data(read_data), .busy(busy), .done(done), .error(error));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [23:0] act, input logic [23:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d actual %h required %h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0 && cyc == q[0].cyc) begin
      chk("done", {23'b0, done}, 24'd1);
      chk("busy_at_done", {23'b0, busy}, 24'd0);
      chk("error", {23'b0, error}, {23'b0, q[0].err});
      chk("read_data", read_data & q[0].mask, q[0].data & q[0].mask);
      void'(q.pop_front());
    end else begin
      chk("no_done", {23'b0, done}, 24'd0);
      if (q.size() > 0 && !q[0].err && cyc >= q[0].cyc - 3)
        chk("busy", {23'b0, busy}, 24'd1);
    end
  end

  function automatic logic oob(input logic [23:0] a);
`ifdef BOUNDS_CHECK_EN
    return (a[23:10] != 0) || (a[9:1] == 9'h1FF);
`else
    return a[0] & 1'b0;
`endif
  endfunction

  task automatic push(input logic rd, input logic wr, input logic [23:0] a,
                      input logic [23:0] exp_data, input logic [23:0] mask, input int at);
    logic err;
    err = (rd & wr) | oob(a);
    if (rd && !err) begin
      rd_model = exp_data;
      rd_mask = mask;
    end
    q.push_back('{at + (err ? 1 : 4), rd_model, rd_mask, err});
  endtask

  task automatic drain();
    for (int i = 0; i < 16 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL timeout cycle %0d actual pending %0d required 0", cyc, q.size());
      q.delete();
    end
  endtask

  task automatic op(input logic rd, input logic wr, input logic [23:0] a, input logic [23:0] wd,
                    input logic [23:0] exp_data, input logic [23:0] mask);
    @(negedge clk);
    mem_read = rd;
    mem_write = wr;
    address = a;
    write_data = wd;
    push(rd, wr, a, exp_data, mask, cyc);
    @(posedge clk);
    #1;
    mem_read = 1'b0;
    mem_write = 1'b0;
    address = 24'hFFFFFF;
    write_data = 24'h5A5A5A;
    drain();
  endtask

  initial begin
    int c;
    reset = 1'b1;
    mem_read = 1'b0;
    mem_write = 1'b0;
    address = '0;
    write_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {23'b0, busy}, 24'd0);
    chk("rst_done", {23'b0, done}, 24'd0);
    chk("rst_error", {23'b0, error}, 24'd0);
    chk("rst_read_data", read_data, 24'd0);
    reset = 1'b0;
    op(0, 1, 24'h000010, 24'hA1B2C3, 0, 0);
    op(1, 0, 24'h000010, 0, 24'hA1B2C3, 24'hFFFFFF);
    op(0, 1, 24'h000020, 24'h112233, 0, 0);
    op(0, 1, 24'h000022, 24'h445566, 0, 0);
    op(1, 0, 24'h000020, 0, 24'h112244, 24'hFFFFFF);
    op(1, 0, 24'h000022, 0, 24'h445566, 24'hFFFFFF);
    op(1, 1, 24'h000010, 24'h000000, 0, 0);
    op(1, 0, 24'h000010, 0, 24'hA1B2C3, 24'hFFFFFF);
    op(1, 0, 24'hFFF010, 0, 24'hA1B2C3, 24'hFFFFFF);
    op(0, 1, 24'h0003FF, 24'hDEADBE, 0, 0);
    op(1, 0, 24'h0003FF, 0, 24'hDEADBE, 24'hFFFFFF);
    op(1, 0, 24'h000000, 0, 24'hADBE00, WRAP_MASK);
    op(0, 1, 24'h000040, 24'h010203, 0, 0);
    @(negedge clk);
    mem_write = 1'b1;
    address = 24'h000040;
    write_data = 24'h778899;
    @(posedge clk);
    #1;
    mem_write = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_rst_busy", {23'b0, busy}, 24'd0);
    chk("mid_rst_done", {23'b0, done}, 24'd0);
    chk("mid_rst_error", {23'b0, error}, 24'd0);
    chk("mid_rst_read_data", read_data, 24'd0);
    rd_model = '0;
    rd_mask = 24'hFFFFFF;
    op(1, 0, 24'h000040, 0, 24'h770003, 24'hFF00FF);
    @(negedge clk);
    mem_read = 1'b1;
    address = 24'h000010;
    c = cyc;
    push(1, 0, 24'h000010, 24'hA1B2C3, 24'hFFFFFF, c);
    push(1, 0, 24'h000010, 24'hA1B2C3, 24'hFFFFFF, c + 5);
    while (cyc < c + 9) @(negedge clk);
    mem_read = 1'b0;
    drain();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
